// File: rtl/serial_demux_rx_if.sv
// Handshake bundle between the serial line driver, the demux receiver and the
// consuming logic.
interface serial_demux_rx_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             overrun_clr;

    modport master (
        output din, din_valid, frame_start, dout_ready, overrun_clr,
        input  dout, dout_valid, overrun
    );

    modport slave (
        input  din, din_valid, frame_start, dout_ready, overrun_clr,
        output dout, dout_valid, overrun
    );
endinterface

// File: rtl/serial_demux_rx.sv
// Serial-to-parallel receiver: assembles framed bit streams into WIDTH-bit words
// and presents them on a registered valid/ready output with a sticky overrun flag.
module serial_demux_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    serial_demux_rx_if.slave bus
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             complete, load, drop;

    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] k);
        return LSB_FIRST ? k : (LAST - k);
    endfunction

    function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] word,
                                                   input logic [CNT_W-1:0] k,
                                                   input logic             b);
        logic [WIDTH-1:0] w;
        w              = word;
        w[bit_pos(k)] = b;
        return w;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        complete     = 1'b0;
        load         = 1'b0;
        drop         = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        // A framed bit always restarts the word, even on what would be the last bit.
        if (bus.din_valid) begin
            if (bus.frame_start) begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(1);
                shift_d = place_bit('0, '0, bus.din);
            end else if (state_q == SHIFT) begin
                shift_d = place_bit(shift_q, cnt_q, bus.din);
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        load = complete && (!dout_valid_q || bus.dout_ready);
        drop = complete && dout_valid_q && !bus.dout_ready;

        if (load) begin
            dout_d       = shift_d;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_demux_rx.sv
// Directed bench for serial_demux_rx: an LSB-first instance checked through a
// word scoreboard, plus an MSB-first instance sharing the same serial stream.
module tb_serial_demux_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic frame_start = 1'b0;
    logic dout_ready = 1'b1;
    logic overrun_clr = 1'b0;

    int n_err = 0;
    int n_checks = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    serial_demux_rx_if #(.WIDTH(8)) i0 ();
    serial_demux_rx_if #(.WIDTH(8)) i1 ();

    assign i0.din         = din;
    assign i0.din_valid   = din_valid;
    assign i0.frame_start = frame_start;
    assign i0.dout_ready  = dout_ready;
    assign i0.overrun_clr = overrun_clr;

    assign i1.din         = din;
    assign i1.din_valid   = din_valid;
    assign i1.frame_start = frame_start;
    assign i1.dout_ready  = 1'b1;
    assign i1.overrun_clr = 1'b0;

    serial_demux_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (i0.slave)
    );

    serial_demux_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (i1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluated just before the rising edge, with the inputs that edge will see.
    task automatic monitor();
        logic [7:0] exp_w;
        if (i0.dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", {24'd0, i0.dout}, 32'hFFFF_FFFF);
            end else begin
                exp_w = sb_q.pop_front();
                check("sb_word", {24'd0, i0.dout}, {24'd0, exp_w});
            end
        end
    endtask

    task automatic clk_edge();
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic fs);
        din         = b;
        din_valid   = 1'b1;
        frame_start = fs;
        clk_edge();
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic framed);
        for (int k = 0; k < 8; k++) send_bit(w[k], framed && (k == 0));
    endtask

    initial begin
        logic [7:0] w;

        // Reset
        rst_n = 1'b0;
        clk_edge();
        clk_edge();
        rst_n = 1'b1;
        check("rst_dout", {24'd0, i0.dout}, 32'h0);
        check("rst_valid", {31'd0, i0.dout_valid}, 32'h0);
        check("rst_overrun", {31'd0, i0.overrun}, 32'h0);
        check("rst_valid_msb", {31'd0, i1.dout_valid}, 32'h0);

        // Basic LSB-first word, single-cycle valid
        dout_ready = 1'b1;
        sb_q.push_back(8'hA5);
        send_word(8'hA5, 1'b1);
        check("basic_valid", {31'd0, i0.dout_valid}, 32'h1);
        check("basic_dout", {24'd0, i0.dout}, 32'hA5);
        clk_edge();
        check("basic_valid_1cyc", {31'd0, i0.dout_valid}, 32'h0);
        check("basic_overrun", {31'd0, i0.overrun}, 32'h0);

        // MSB-first with a 3-cycle gap between bits 3 and 4
        sb_q.push_back(8'hA5);
        w = 8'hA5;
        for (int k = 0; k < 4; k++) send_bit(w[k], k == 0);
        for (int g = 0; g < 3; g++) begin
            clk_edge();
            check("gap_valid_msb", {31'd0, i1.dout_valid}, 32'h0);
            check("gap_valid_lsb", {31'd0, i0.dout_valid}, 32'h0);
        end
        for (int k = 4; k < 8; k++) send_bit(w[k], 1'b0);
        check("msb_valid", {31'd0, i1.dout_valid}, 32'h1);
        check("msb_dout", {24'd0, i1.dout}, 32'hA5);
        clk_edge();

        // Back-to-back under backpressure, then clear and consume
        dout_ready = 1'b0;
        sb_q.push_back(8'h3C);
        send_word(8'h3C, 1'b1);
        check("bp_first_valid", {31'd0, i0.dout_valid}, 32'h1);
        check("bp_first_overrun", {31'd0, i0.overrun}, 32'h0);
        send_word(8'hFF, 1'b0);
        check("bp_overrun", {31'd0, i0.overrun}, 32'h1);
        check("bp_dout_held", {24'd0, i0.dout}, 32'h3C);
        check("bp_valid_held", {31'd0, i0.dout_valid}, 32'h1);
        overrun_clr = 1'b1;
        clk_edge();
        overrun_clr = 1'b0;
        check("clr_overrun", {31'd0, i0.overrun}, 32'h0);
        check("clr_dout", {24'd0, i0.dout}, 32'h3C);
        dout_ready = 1'b1;
        clk_edge();
        check("consume_valid", {31'd0, i0.dout_valid}, 32'h0);
        check("consume_dout_kept", {24'd0, i0.dout}, 32'h3C);

        // Resync: partial 0x0F discarded, 0x81 delivered
        w = 8'h0F;
        for (int k = 0; k < 5; k++) send_bit(w[k], k == 0);
        sb_q.push_back(8'h81);
        send_word(8'h81, 1'b1);
        check("resync_dout", {24'd0, i0.dout}, 32'h81);
        clk_edge();
        check("resync_overrun", {31'd0, i0.overrun}, 32'h0);

        // Reset mid-word, unframed bits ignored, then framed 0x5A
        w = 8'hC3;
        for (int k = 0; k < 4; k++) send_bit(w[k], k == 0);
        rst_n = 1'b0;
        clk_edge();
        rst_n = 1'b1;
        check("midrst_dout", {24'd0, i0.dout}, 32'h0);
        check("midrst_valid", {31'd0, i0.dout_valid}, 32'h0);
        check("midrst_overrun", {31'd0, i0.overrun}, 32'h0);
        send_word(8'hFF, 1'b0);
        check("unframed_ignored", {31'd0, i0.dout_valid}, 32'h0);
        sb_q.push_back(8'h5A);
        send_word(8'h5A, 1'b1);
        check("after_rst_dout", {24'd0, i0.dout}, 32'h5A);
        clk_edge();

        // Same-edge load and consume
        dout_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_word(8'h11, 1'b1);
        sb_q.push_back(8'h22);
        w = 8'h22;
        for (int k = 0; k < 7; k++) send_bit(w[k], 1'b0);
        dout_ready = 1'b1;
        send_bit(w[7], 1'b0);
        check("same_edge_dout", {24'd0, i0.dout}, 32'h22);
        check("same_edge_valid", {31'd0, i0.dout_valid}, 32'h1);
        check("same_edge_overrun", {31'd0, i0.overrun}, 32'h0);
        clk_edge();
        clk_edge();

        check("sb_drained", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_demux_rx.md
Name: serial_demux_rx

Overview:
- Receive side of the team's mux-based serial link: rebuilds parallel words from a time-multiplexed single-bit stream.
- Shifts bits qualified by `din_valid` into a WIDTH-bit word. A `frame_start` strobe aligns word boundaries.
- Presents each completed word on a valid/ready output register.
- Sits between the serial line driver (a 2:1 NAND-mux selector tree) and the consuming logic.

Parameters:
- WIDTH, 8, word length in bits; legal values 2..32.
- LSB_FIRST, 1, 1: first received bit lands in `dout[0]`; 0: first received bit lands in `dout[WIDTH-1]`.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- din  input  1  serial data bit.
- din_valid  input  1  `din` is sampled on this edge only when high.
- frame_start  input  1  qualified by `din_valid`; marks the current bit as bit 0 of a new word.
- dout  output  WIDTH  completed word.
- dout_valid  output  1  `dout` holds an unconsumed word.
- dout_ready  input  1  consumer accepts `dout` on an edge where `dout_valid && dout_ready`.
- overrun  output  1  sticky flag: a completed word was dropped.
- overrun_clr  input  1  clears `overrun`.

Behaviour:
- Reset (`rst_n` = 0 at an edge): state=IDLE, bit counter=0, shift register=0, `dout`=0, `dout_valid`=0, `overrun`=0. Reset overrides every other input. A partial word is discarded with no output.
- Counter width: `$clog2(WIDTH)`.
- State IDLE:
  - `din_valid && !frame_start` is ignored.
  - `din_valid && frame_start` stores `din` as bit 0, sets counter=1, moves to SHIFT.
- State SHIFT, edges with `din_valid`=0: nothing changes. Gaps of any length are allowed.
- State SHIFT, `din_valid && !frame_start`: stores `din` at position = counter, counter++.
- State SHIFT, `din_valid && frame_start`: resync. The partial word is discarded and not flagged. `din` becomes bit 0 and counter=1.
- Bit placement:
  - LSB_FIRST=1: bit k goes to `word[k]`.
  - LSB_FIRST=0: bit k goes to `word[WIDTH-1-k]`.
- Word completion: the edge that stores bit WIDTH-1.
  - Counter returns to 0 and the state stays SHIFT. The next valid bit is bit 0 of the next word; `frame_start` is not required for back-to-back words.
- Completion when the output register is free (`dout_valid`=0, or `dout_ready`=1 on the same edge):
  - `dout` <= assembled word and `dout_valid` <= 1 on that edge.
  - Latency: `dout_valid` is high in the cycle after the last bit's edge.
- Completion when the output register is busy (`dout_valid`=1 and `dout_ready`=0):
  - The new word is dropped, `dout` is unchanged, and `overrun` <= 1.
- Consume: `dout_valid && dout_ready` with no completion on the same edge sets `dout_valid` <= 0. `dout` keeps its last value.
- `dout` changes only on a loaded completion; it is stable while `dout_valid`=1.
- `overrun`:
  - Set by a dropped word.
  - Cleared by `overrun_clr`=1 at an edge.
  - Set wins if a drop and `overrun_clr` occur on the same edge.
- `frame_start` with `din_valid`=0 is ignored.
- Resync on the edge that would have been bit WIDTH-1 takes priority: the bit becomes bit 0 and no word completes.
- Output signals are registered only; there are no combinational input-to-output paths.

Test Plan:
- Basic word: WIDTH=8, LSB_FIRST=1, `dout_ready`=1; `frame_start` with first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> `dout`=0xA5 and `dout_valid`=1 for exactly 1 cycle, starting the cycle after the 8th bit; `overrun`=0.
- MSB first with gaps: LSB_FIRST=0; same bit sequence 1,0,1,0,0,1,0,1 with `din_valid` low for 3 cycles between bits 3 and 4 -> `dout`=0xA5; no output during the gaps.
- Back-to-back and backpressure: `dout_ready`=0; send 0x3C then 0xFF contiguously (single `frame_start`) -> `dout`=0x3C held with `dout_valid`=1, `overrun`=1 after the 16th bit. Then pulse `overrun_clr` -> `overrun`=0, `dout` still 0x3C. Then `dout_ready`=1 for one edge -> `dout_valid`=0.
- Resync: send 5 bits of 0x0F, then `frame_start` with a new 8-bit word 0x81 -> only 0x81 is output; no overrun.
- Reset mid-word: 4 bits received, `rst_n`=0 for 1 edge -> all outputs 0. Bits without `frame_start` are ignored. A later framed 0x5A outputs correctly.
- Same-edge load and consume: `dout_valid`=1 with word 0x11 pending; assert `dout_ready` on the edge completing 0x22 -> `dout`=0x22, `dout_valid` stays 1, `overrun`=0.
